l1ca_code_ctrl: RTL

//  Sequencer for one L1 C/A code generator in a tracking channel. Converts a code-rate NCO word into chip-advance

---
 rtl/common_gnss_types_pkg.sv | 27 ++
 rtl/l1ca_code_nco.sv | 34 +++
 rtl/l1ca_code_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/common_gnss_types_pkg.sv
// Shared GNSS types and constants for the L1 C/A code channel blocks.
package common_gnss_types_pkg;

   // PRN select (0..31) and code chip index (0..1022)
   typedef logic [4:0] sv_t;
   typedef logic [9:0] gps_chip_t;

   // Code controller sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_SLEW = 2'd3
   } ctrl_state_t;

   localparam int unsigned L1CA_CHIPS_PER_EPOCH = 1023;
   localparam int unsigned L1CA_MS_PER_BIT      = 20;

   localparam gps_chip_t  L1CA_LAST_CHIP = gps_chip_t'(L1CA_CHIPS_PER_EPOCH - 1);
   localparam logic [4:0] L1CA_LAST_MS   = 5'(L1CA_MS_PER_BIT - 1);

   // True when the generator sits on the final chip of the 1 ms epoch
   function automatic logic is_last_chip(input gps_chip_t chip);
      return (chip == L1CA_LAST_CHIP);
   endfunction

endpackage

// File: rtl/l1ca_code_nco.sv
// Code-rate NCO: phase accumulator whose carry-out marks one chip advance.
// clear zeroes the phase; hold freezes it (carry is still computed but
// the caller decides whether it is used).
module l1ca_code_nco #(
   parameter int NCO_W = 32
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             clear,
   input  logic             hold,
   input  logic [NCO_W-1:0] rate,
   output logic             carry
);

   logic [NCO_W-1:0] r_accum;
   logic [NCO_W:0]   w_sum;

   assign w_sum = {1'b0, r_accum} + {1'b0, rate};
   assign carry = w_sum[NCO_W];

   // Phase accumulator: clear has priority, then hold, else advance by rate
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_accum <= '0;
      end else if (clear) begin
         r_accum <= '0;
      end else if (hold) begin
         r_accum <= r_accum;
      end else begin
         r_accum <= w_sum[NCO_W-1:0];
      end
   end

endmodule

// File: rtl/l1ca_code_ctrl.sv
// L1 C/A code generator sequencer for one tracking channel.
// Turns the code NCO carry into chip-advance enables, drives generator
// clear / PRN select, performs fast code-phase slews and emits epoch strobes.
// Optional build macro L1CA_CTRL_EPOCH_CNT_EN adds the ms-within-bit counter
// and bit-edge strobe; without it ms_count and bit_edge are tied to zero.
module l1ca_code_ctrl
   import common_gnss_types_pkg::*;
#(
   parameter int NCO_W = 32
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             start,
   input  logic             stop,
   input  sv_t              sv_in,
   input  logic [NCO_W-1:0] code_rate,
   input  logic             slew_valid,
   input  logic [9:0]       slew_chips,
   input  gps_chip_t        gen_chip,
   output logic             gen_en,
   output logic             gen_clear,
   output sv_t              gen_sv,
   output logic             slew_ready,
   output logic             busy,
   output logic             epoch_pulse,
   output logic [4:0]       ms_count,
   output logic             bit_edge
);

   ctrl_state_t r_state;
   ctrl_state_t w_next;
   logic [9:0]  r_remaining;
   sv_t         r_sv;
   logic        r_epoch;
   logic        w_carry;
   logic        w_gen_en;
   logic        w_slew_acc;
   logic        w_nco_clear;
   logic        w_nco_hold;

   // A slew is taken only from RUN and never in a cycle that is stopping
   assign w_slew_acc  = (r_state == ST_RUN) && slew_valid && !stop;
   assign w_nco_clear = (r_state == ST_LOAD);
   assign w_nco_hold  = (r_state != ST_RUN) || stop;

   l1ca_code_nco #(
      .NCO_W (NCO_W)
   ) u_nco (
      .clk   (clk),
      .nrst  (nrst),
      .clear (w_nco_clear),
      .hold  (w_nco_hold),
      .rate  (code_rate),
      .carry (w_carry)
   );

   // State register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and chip-advance enable; stop overrides everything
   always_comb begin
      w_next   = r_state;
      w_gen_en = 1'b0;
      if (stop) begin
         w_next   = ST_IDLE;
         w_gen_en = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  w_next = ST_LOAD;
               end else begin
                  w_next = ST_IDLE;
               end
            end
            ST_LOAD: begin
               w_next = ST_RUN;
            end
            ST_RUN: begin
               w_gen_en = w_carry;
               if (slew_valid && (slew_chips != 10'd0)) begin
                  w_next = ST_SLEW;
               end else begin
                  w_next = ST_RUN;
               end
            end
            ST_SLEW: begin
               w_gen_en = 1'b1;
               if (r_remaining == 10'd1) begin
                  w_next = ST_RUN;
               end else begin
                  w_next = ST_SLEW;
               end
            end
            default: begin
               w_next   = ST_IDLE;
               w_gen_en = 1'b0;
            end
         endcase
      end
   end

   // Slew chip counter: load on accept, count down while slewing
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_remaining <= 10'd0;
      end else if (w_slew_acc) begin
         r_remaining <= slew_chips;
      end else if (r_state == ST_SLEW) begin
         r_remaining <= r_remaining - 10'd1;
      end else begin
         r_remaining <= r_remaining;
      end
   end

   // PRN latch, updated only on a start that is actually accepted
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_sv <= 5'd0;
      end else if ((r_state == ST_IDLE) && start && !stop) begin
         r_sv <= sv_in;
      end else begin
         r_sv <= r_sv;
      end
   end

   // Epoch strobe: the enable that moves the generator off its last chip
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_epoch <= 1'b0;
      end else begin
         r_epoch <= w_gen_en && is_last_chip(gen_chip);
      end
   end

`ifdef L1CA_CTRL_EPOCH_CNT_EN
   logic [4:0] r_ms;
   logic       r_bit_edge;

   // ms-within-bit counter, restarted whenever the channel is (re)loaded
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_ms       <= 5'd0;
         r_bit_edge <= 1'b0;
      end else if ((r_state == ST_IDLE) || (r_state == ST_LOAD)) begin
         r_ms       <= 5'd0;
         r_bit_edge <= 1'b0;
      end else if (r_epoch) begin
         if (r_ms == L1CA_LAST_MS) begin
            r_ms       <= 5'd0;
            r_bit_edge <= 1'b1;
         end else begin
            r_ms       <= r_ms + 5'd1;
            r_bit_edge <= 1'b0;
         end
      end else begin
         r_ms       <= r_ms;
         r_bit_edge <= 1'b0;
      end
   end

   assign ms_count = r_ms;
   assign bit_edge = r_bit_edge;
`else
   assign ms_count = 5'd0;
   assign bit_edge = 1'b0;
`endif

   assign gen_en      = w_gen_en;
   assign gen_clear   = (r_state == ST_LOAD);
   assign gen_sv      = r_sv;
   assign slew_ready  = (r_state == ST_RUN);
   assign busy        = (r_state != ST_IDLE);
   assign epoch_pulse = r_epoch;

endmodule
